cla_serial_adder: RTL and testbench

Multi-cycle wide adder that sequences a single 4-bit CarryLookAheadAdder over NIBBLES nibble slices, one slice per clock, least-significant first, with a registered carry between slices. It sits directly upstream of the 4-bit CLA and drives that adder's a/b/cin inputs. It accepts operands through a valid/ready handshake and presents the full-width sum and carry-out through a second valid/ready handshake.

---
 rtl/cla_serial_adder.sv | 153 +++++++++++++++
 tb/tb_cla_serial_adder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cla_serial_adder.sv
// rtl/cla_serial_adder.sv - multi-cycle wide adder sequencing one 4-bit CLA over nibble slices

module CarryLookAheadAdder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    // Two-level lookahead: every carry is a flat sum of generate/propagate products
    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[3:0];
        cout = c[4];
    end
endmodule

module cla_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic            carry_q;
    logic            cout_q;
    logic [IW-1:0]   idx;
    logic [3:0]      nib_a;
    logic [3:0]      nib_b;
    logic [3:0]      cla_sum;
    logic            cla_cout;
    logic            last;

    // Select the current nibble of the latched operands for the shared adder
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IW'(i)) begin
                nib_a = a_q[4*i +: 4];
                nib_b = b_q[4*i +: 4];
            end
        end
        last = (idx == IW'(NIBBLES - 1));
    end

    CarryLookAheadAdder u_cla (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: accept in IDLE, step slices in RUN, wait for consumer in DONE
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (in_valid) state_nx = S_RUN;
            S_RUN:   if (last) state_nx = S_DONE;
            S_DONE:  if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Handshake outputs decode from state alone, so they are mutually exclusive
    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
    end

    // Datapath: latch operands on accept, fill one sum slice per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx     <= '0;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (idx == IW'(i)) begin
                            sum_q[4*i +: 4] <= cla_sum;
                        end
                    end
                    carry_q <= cla_cout;
                    if (last) begin
                        cout_q <= cla_cout;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_cla_serial_adder.sv
// tb/tb_cla_serial_adder.sv - directed self-checking bench for cla_serial_adder

module tb_cla_serial_adder;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;

    logic        in_valid1;
    logic        in_ready1;
    logic [3:0]  a1;
    logic [3:0]  b1;
    logic        cin1;
    logic        out_valid1;
    logic        out_ready1;
    logic [3:0]  sum1;
    logic        cout1;

    int n_checks;
    int n_fail;

    cla_serial_adder #(.NIBBLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
    );

    cla_serial_adder #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] va, input logic [15:0] vb, input logic vc);
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat, output bit to);
        lat = 0;
        to  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            lat++;
            if (out_valid) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        n_checks++; if (sum !== 16'h0000 || cout !== 1'b0) begin n_fail++; $display("FAIL reset_result got %h/%0b want 0000/0", sum, cout); end
        n_checks++; if (out_valid1 !== 1'b0 || sum1 !== 4'h0 || cout1 !== 1'b0) begin n_fail++; $display("FAIL reset_n1 got v%0b %h/%0b want v0 0/0", out_valid1, sum1, cout1); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat; bit to;
        issue(16'h000B, 16'h0006, 1'b0);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_in_ready_run got %0b want 0", in_ready); end
        wait_valid(lat, to);
        n_checks++; if (to || lat != 4) begin n_fail++; $display("FAIL basic_latency got %0d (timeout %0b) want 4", lat, to); end
        n_checks++; if (sum !== 16'h0011 || cout !== 1'b0) begin n_fail++; $display("FAIL basic_sum got %h/%0b want 0011/0", sum, cout); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_exclusive got in_ready %0b want 0", in_ready); end
        consume();
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_post got r%0b v%0b want r1 v0", in_ready, out_valid); end
    endtask

    task automatic test_carry_chain();
        int lat; bit to;
        issue(16'hFFFF, 16'h0001, 1'b0);
        wait_valid(lat, to);
        n_checks++; if (to || sum !== 16'h0000 || cout !== 1'b1) begin n_fail++; $display("FAIL carry_chain got %h/%0b (timeout %0b) want 0000/1", sum, cout, to); end
        consume();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        a = 16'h0000; b = 16'h0000; cin = 1'b1; in_valid = 1'b1;
        tick();
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
        tick(); tick(); tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_early_valid got %0b want 0", out_valid); end
        tick();
        n_checks++; if (out_valid !== 1'b1 || sum !== 16'h0001 || cout !== 1'b0) begin n_fail++; $display("FAIL b2b_first got v%0b %h/%0b want v1 0001/0", out_valid, sum, cout); end
        tick();
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got r%0b v%0b want r1 v0", in_ready, out_valid); end
        tick();
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_second_accept got in_ready %0b want 0", in_ready); end
        tick(); tick(); tick(); tick();
        n_checks++; if (out_valid !== 1'b1 || sum !== 16'hFFFF || cout !== 1'b1) begin n_fail++; $display("FAIL b2b_second got v%0b %h/%0b want v1 FFFF/1", out_valid, sum, cout); end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int lat; bit to;
        issue(16'h1234, 16'h4321, 1'b0);
        wait_valid(lat, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL bp_first_timeout got none want out_valid"); end
        a = 16'h0F0F; b = 16'h0101; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || sum !== 16'h5555 || cout !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d got r%0b v%0b %h/%0b want r0 v1 5555/0", i, in_ready, out_valid, sum, cout);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got r%0b v%0b want r1 v0", in_ready, out_valid); end
        tick();
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_next_accept got in_ready %0b want 0", in_ready); end
        wait_valid(lat, to);
        n_checks++; if (to || lat != 4 || sum !== 16'h1010 || cout !== 1'b0) begin n_fail++; $display("FAIL bp_next_result got %h/%0b lat %0d want 1010/0 lat 4", sum, cout, lat); end
        consume();
    endtask

    task automatic test_no_sample();
        bit done;
        done = 1'b0;
        issue(16'h1234, 16'h1111, 1'b0);
        for (int i = 0; i < 20 && !done; i++) begin
            in_valid = ~in_valid;
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            tick();
            if (out_valid) done = 1'b1;
        end
        in_valid = 1'b0;
        n_checks++; if (!done || sum !== 16'h2345 || cout !== 1'b0) begin n_fail++; $display("FAIL no_sample got %h/%0b done %0b want 2345/0", sum, cout, done); end
        consume();
    endtask

    task automatic test_reset_mid_run();
        int lat; bit to;
        issue(16'h1111, 16'h2222, 1'b0);
        tick(); tick();
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0) begin n_fail++; $display("FAIL midrun_reset got v%0b %h/%0b want v0 0000/0", out_valid, sum, cout); end
        tick();
        rst_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL midrun_release got r%0b v%0b want r1 v0", in_ready, out_valid); end
        issue(16'h8000, 16'h8000, 1'b0);
        wait_valid(lat, to);
        n_checks++; if (to || sum !== 16'h0000 || cout !== 1'b1) begin n_fail++; $display("FAIL midrun_after got %h/%0b want 0000/1", sum, cout); end
        consume();
    endtask

    task automatic test_nibbles_one();
        a1 = 4'hF; b1 = 4'h1; cin1 = 1'b0; in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        n_checks++; if (in_ready1 !== 1'b0 || out_valid1 !== 1'b0) begin n_fail++; $display("FAIL n1_run got r%0b v%0b want r0 v0", in_ready1, out_valid1); end
        tick();
        n_checks++; if (out_valid1 !== 1'b1 || sum1 !== 4'h0 || cout1 !== 1'b1) begin n_fail++; $display("FAIL n1_result got v%0b %h/%0b want v1 0/1", out_valid1, sum1, cout1); end
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        n_checks++; if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || sum1 !== 4'h0 || cout1 !== 1'b1) begin n_fail++; $display("FAIL n1_post got r%0b v%0b %h/%0b want r1 v0 0/1", in_ready1, out_valid1, sum1, cout1); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        test_reset();
        test_basic();
        test_carry_chain();
        test_back_to_back();
        test_backpressure();
        test_no_sample();
        test_reset_mid_run();
        test_nibbles_one();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
